// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin serialiser of set/clear pulses onto a bank of SR latches, with Q feedback check.
// Latency: request at edge k drives S/R from edge k+1; ack one cycle after settle; requests never stall.
module sr_latch_bank_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int PULSE_LEN  = 2,
  parameter int SETTLE_LEN = 1,
  parameter int RESET_WINS = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_CH-1:0]         set_req,
  input  logic [NUM_CH-1:0]         clr_req,
  input  logic                      fault_clr,
  input  logic [NUM_CH-1:0]         q_fb,
  output logic [NUM_CH-1:0]         s_out,
  output logic [NUM_CH-1:0]         r_out,
  output logic [NUM_CH-1:0]         ack,
  output logic                      busy,
  output logic [NUM_CH-1:0]         shadow,
  output logic [NUM_CH-1:0]         shadow_valid,
  output logic                      fault,
  output logic [$clog2(NUM_CH)-1:0] fault_ch
);

  localparam int   CW   = $clog2(NUM_CH);
  localparam int   CNTW = 16;
  localparam logic RW   = (RESET_WINS != 0);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     ch, ch_nx, ptr, pick;
  logic              op_set, op_set_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [NUM_CH-1:0] pend_set, pend_clr, pend_set_nx, pend_clr_nx;
  logic [NUM_CH-1:0] onehot_nx, onehot_cur;
  logic              found, done, mismatch;
  logic              set_win, clr_win;

  // Walk offsets from far to near so the nearest pending channel after ptr wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = NUM_CH; off >= 1; off--) begin
      logic [CW-1:0] idx;
      idx = CW'((int'(ptr) + off) % NUM_CH);
      if (pend_set[idx] | pend_clr[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    ch_nx       = ch;
    op_set_nx   = op_set;
    cnt_nx      = cnt;
    pend_set_nx = pend_set;
    pend_clr_nx = pend_clr;
    done        = 1'b0;
    mismatch    = 1'b0;
    set_win     = 1'b0;
    clr_win     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          ch_nx             = pick;
          op_set_nx         = pend_set[pick];
          pend_set_nx[pick] = 1'b0;
          pend_clr_nx[pick] = 1'b0;
          cnt_nx            = CNTW'(PULSE_LEN - 1);
          state_nx          = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          cnt_nx   = CNTW'(SETTLE_LEN - 1);
          state_nx = SETTLE;
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          done     = 1'b1;
          mismatch = (q_fb[ch] != op_set);
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // New requests land after dequeue so the in-service channel can re-queue.
    for (int i = 0; i < NUM_CH; i++) begin
      set_win = set_req[i] & (~clr_req[i] | ~RW);
      clr_win = clr_req[i] & (~set_req[i] | RW);
      if (set_win) begin
        pend_set_nx[i] = 1'b1;
        pend_clr_nx[i] = 1'b0;
      end else if (clr_win) begin
        pend_clr_nx[i] = 1'b1;
        pend_set_nx[i] = 1'b0;
      end
    end
  end

  assign onehot_nx  = NUM_CH'(1) << ch_nx;
  assign onehot_cur = NUM_CH'(1) << ch;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      ch           <= '0;
      op_set       <= 1'b0;
      cnt          <= '0;
      ptr          <= CW'(NUM_CH - 1);
      pend_set     <= '0;
      pend_clr     <= '0;
      s_out        <= '0;
      r_out        <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      shadow       <= '0;
      shadow_valid <= '0;
      fault        <= 1'b0;
      fault_ch     <= '0;
    end else begin
      state    <= state_nx;
      ch       <= ch_nx;
      op_set   <= op_set_nx;
      cnt      <= cnt_nx;
      pend_set <= pend_set_nx;
      pend_clr <= pend_clr_nx;
      s_out    <= (state_nx == PULSE &&  op_set_nx) ? onehot_nx : '0;
      r_out    <= (state_nx == PULSE && !op_set_nx) ? onehot_nx : '0;
      busy     <= (state_nx != IDLE);
      ack      <= done ? onehot_cur : '0;
      if (done) begin
        shadow[ch]       <= op_set;
        shadow_valid[ch] <= 1'b1;
        ptr              <= ch;
      end
      // A mismatch seen on the clearing edge re-arms the fault with the new channel.
      if (mismatch && (!fault || fault_clr)) begin
        fault    <= 1'b1;
        fault_ch <= ch;
      end else if (fault_clr) begin
        fault    <= 1'b0;
        fault_ch <= '0;
      end
    end
  end

endmodule
